// File: rtl/vga_pkg.sv
// Shared VGA types and constants: RGB565 pixel layout, 640x480@60 timing, basic colours.
package vga_pkg;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam rgb565_t BLACK = '{r: 5'h00, g: 6'h00, b: 5'h00};
  localparam rgb565_t GREEN = '{r: 5'h00, g: 6'h3f, b: 5'h00};
  localparam rgb565_t BLUE  = '{r: 5'h00, g: 6'h00, b: 5'h1f};
  localparam rgb565_t RED   = '{r: 5'h1f, g: 6'h00, b: 5'h00};

endpackage

// File: rtl/vga_fb_fifo.sv
// Show-ahead prefetch FIFO; the caller only pushes when not full and pops when not empty.
module vga_fb_fifo
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [DW-1:0]          push_data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [DW-1:0]          head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;

  // Flush drops everything by snapping the read pointer onto the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= wr_ptr_q;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: sequential scan-out prefetch with priority over a pixel writer
// only while the prefetch occupancy is below half, otherwise the writer wins.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned HWIDTH     = H_VISIBLE,
  parameter int unsigned VWIDTH     = V_VISIBLE,
  parameter int unsigned AW         = 19,
  parameter int unsigned DW         = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic          pix_rd,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid,
  output logic          underrun,
  input  logic          underrun_clr,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  output logic          ram_re,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned AW1 = AW + 1;
  localparam logic [AW1-1:0] FRAME_PIX = AW1'(HWIDTH * VWIDTH);
  localparam logic [CW-1:0]  DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]  HALF_C    = CW'(FIFO_DEPTH / 2);

  logic [AW-1:0]     scan_addr_q, scan_addr_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic [CW-1:0]     discard_q, discard_d;
  logic              underrun_q, underrun_d;
  logic              ram_re_q, ram_we_q;
  logic [AW-1:0]     ram_addr_q, ram_addr_d;
  logic [DW-1:0]     ram_wdata_q, ram_wdata_d;
  logic [RD_LAT-1:0] rvalid_q;

  logic [CW-1:0] fifo_count;
  logic [CW-1:0] occ;
  logic          fifo_empty, fifo_full;
  logic          fifo_push, fifo_pop;
  logic          scan_ok, urgent, rd_ret;
  logic          grant_rd, grant_wr;

  vga_fb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (fifo_push),
    .push_data_i (ram_rdata),
    .pop_i       (fifo_pop),
    .flush_i     (frame_start),
    .head_o      (pix_data),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  // Occupancy counts in-flight reads so returning data always has a FIFO slot.
  always_comb begin
    occ         = fifo_count + inflight_q;
    scan_ok     = (occ < DEPTH_C) && ({1'b0, scan_addr_q} < FRAME_PIX) && !frame_start;
    urgent      = (occ < HALF_C);
    rd_ret      = rvalid_q[RD_LAT-1];
    grant_rd    = 1'b0;
    grant_wr    = 1'b0;
    scan_addr_d = scan_addr_q;
    discard_d   = discard_q;
    underrun_d  = underrun_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;

    if (urgent && scan_ok)  grant_rd = 1'b1;
    else if (wr_req)        grant_wr = 1'b1;
    else if (scan_ok)       grant_rd = 1'b1;

    inflight_d = inflight_q + CW'(grant_rd) - CW'(rd_ret);

    if (frame_start)   scan_addr_d = '0;
    else if (grant_rd) scan_addr_d = scan_addr_q + AW'(1);

    // Reads still in flight at a frame restart belong to the old frame and are dropped.
    if (frame_start)                       discard_d = inflight_d;
    else if (rd_ret && discard_q != '0)    discard_d = discard_q - CW'(1);

    fifo_push = rd_ret && (discard_q == '0) && !frame_start && !fifo_full;
    fifo_pop  = pix_rd && !fifo_empty && !frame_start;

    if (underrun_clr)                            underrun_d = 1'b0;
    if (pix_rd && fifo_empty && !frame_start)    underrun_d = 1'b1;

    if (grant_rd) begin
      ram_addr_d = scan_addr_q;
    end else if (grant_wr) begin
      ram_addr_d  = wr_addr;
      ram_wdata_d = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_addr_q <= '0;
      inflight_q  <= '0;
      discard_q   <= '0;
      underrun_q  <= 1'b0;
      ram_re_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      scan_addr_q <= scan_addr_d;
      inflight_q  <= inflight_d;
      discard_q   <= discard_d;
      underrun_q  <= underrun_d;
      ram_re_q    <= grant_rd;
      ram_we_q    <= grant_wr;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  // Read-return tracker: its last stage lines up with ram_rdata being valid.
  if (RD_LAT > 1) begin : g_rvalid_shift
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rvalid_q <= '0;
      else        rvalid_q <= {rvalid_q[RD_LAT-2:0], ram_re_q};
    end
  end else begin : g_rvalid_single
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rvalid_q <= '0;
      else        rvalid_q <= ram_re_q;
    end
  end

  assign wr_ack    = grant_wr & rst_n;
  assign pix_valid = !fifo_empty;
  assign underrun  = underrun_q;
  assign ram_re    = ram_re_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter with a small frame, a latency-accurate RAM model and a random writer.
module tb_vga_fb_arbiter;

  localparam int unsigned HW     = 64;
  localparam int unsigned VW     = 48;
  localparam int unsigned AW     = 19;
  localparam int unsigned DW     = 16;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned FRAME  = HW * VW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          pix_rd = 1'b0;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          underrun;
  logic          underrun_clr = 1'b0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ack;
  logic          ram_re, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  int compared = 0;
  int mismatched = 0;
  int pix_idx = 0;
  int rd_cnt = 0;
  int wr_wait = 0;
  int n_wr = 0;
  int rd_mode = 0;
  bit wr_en = 1'b0;
  logic [AW+DW-1:0] exp_wr [$];
  logic [DW-1:0] pipe [RD_LAT];

  vga_fb_arbiter #(
    .HWIDTH(HW), .VWIDTH(VW), .AW(AW), .DW(DW), .FIFO_DEPTH(DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_rd(pix_rd),
    .pix_data(pix_data), .pix_valid(pix_valid), .underrun(underrun), .underrun_clr(underrun_clr),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .ram_re(ram_re), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM preloaded with data = address[15:0], returned RD_LAT cycles after ram_re.
  always @(posedge clk) begin
    pipe[0] <= ram_re ? ram_addr[15:0] : 16'hDEAD;
    for (int k = 1; k < int'(RD_LAT); k++) pipe[k] <= pipe[k-1];
  end
  assign ram_rdata = pipe[RD_LAT-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: record acks as expected RAM writes, then drive the next cycle's inputs.
  task automatic tick();
    logic ack_seen;
    @(negedge clk);
    ack_seen = wr_ack;
    if (ack_seen) begin
      exp_wr.push_back({wr_addr, wr_data});
      n_wr++;
    end
    @(posedge clk);
    #1;
    frame_start  = 1'b0;
    underrun_clr = 1'b0;
    if (!wr_en) begin
      wr_req = 1'b0;
    end else if (!wr_req || ack_seen) begin
      wr_req  = 1'b1;
      wr_addr = AW'($urandom_range((2 ** AW) - 1, FRAME));
      wr_data = DW'($urandom);
    end
    case (rd_mode)
      1:       pix_rd = 1'b1;
      2:       pix_rd = !pix_rd && ($urandom_range(0, 1) == 1);
      default: pix_rd = 1'b0;
    endcase
  endtask

  // Monitor: read address order, write delivery, writer wait bound, popped pixel stream.
  always @(negedge clk) begin
    if (!rst_n) begin
      pix_idx = 0;
      rd_cnt  = 0;
      wr_wait = 0;
      exp_wr.delete();
    end else begin
      chk("re_we_exclusive", 32'(ram_re & ram_we), 32'd0);
      if (ram_re) begin
        chk("rd_addr", 32'(ram_addr), 32'(rd_cnt));
        chk("rd_in_frame", 32'(rd_cnt < int'(FRAME)), 32'd1);
        rd_cnt++;
      end
      if (ram_we) begin
        if (exp_wr.size() == 0) begin
          chk("wr_unexpected", 32'(ram_we), 32'd0);
        end else begin
          logic [AW+DW-1:0] e;
          e = exp_wr.pop_front();
          chk("wr_addr", 32'(ram_addr), 32'(e[AW+DW-1:DW]));
          chk("wr_data", 32'(ram_wdata), 32'(e[DW-1:0]));
        end
      end
      if (wr_ack) begin
        chk("wr_wait_bound", 32'(wr_wait <= int'(DEPTH / 2)), 32'd1);
        wr_wait = 0;
      end else if (wr_req) begin
        wr_wait++;
      end else begin
        wr_wait = 0;
      end
      if (frame_start) begin
        pix_idx = 0;
        rd_cnt  = 0;
      end else if (pix_rd && pix_valid) begin
        chk("pix_data", 32'(pix_data), 32'(16'(pix_idx)));
        pix_idx++;
      end
    end
  end

  task automatic start_frame_and_fill();
    frame_start = 1'b1;
    tick();
    repeat (40) tick();
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_strobes", 32'({ram_re, ram_we, wr_ack, pix_valid, underrun}), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_pix_data", 32'(pix_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // Prefill after frame_start with no consumer.
    start_frame_and_fill();
    chk("t1_reads", 32'(rd_cnt), 32'd16);
    chk("t1_valid", 32'(pix_valid), 32'd1);
    chk("t1_head", 32'(pix_data), 32'h0000);
    chk("t1_re_idle", 32'(ram_re), 32'd0);

    // Underrun is sticky, clearable, and a new underrun beats a same-cycle clear.
    frame_start = 1'b1;
    tick();
    pix_rd = 1'b1;
    tick();
    chk("t5_underrun_set", 32'(underrun), 32'd1);
    repeat (10) tick();
    chk("t5_underrun_sticky", 32'(underrun), 32'd1);
    underrun_clr = 1'b1;
    tick();
    chk("t5_underrun_clr", 32'(underrun), 32'd0);
    frame_start = 1'b1;
    tick();
    pix_rd = 1'b1;
    underrun_clr = 1'b1;
    tick();
    chk("t5_set_wins", 32'(underrun), 32'd1);
    underrun_clr = 1'b1;
    tick();
    chk("t5_clr_again", 32'(underrun), 32'd0);

    // Restart with two reads in flight: their returns must be dropped.
    frame_start = 1'b1;
    tick();
    tick();
    tick();
    frame_start = 1'b1;
    tick();
    repeat (40) tick();
    chk("t4_head", 32'(pix_data), 32'h0000);
    chk("t4_valid", 32'(pix_valid), 32'd1);
    chk("t4_reads", 32'(rd_cnt), 32'd16);
    rd_mode = 1;
    repeat (200) tick();
    rd_mode = 0;
    tick();
    chk("t4_popped", 32'(pix_idx), 32'd200);
    chk("t4_underrun", 32'(underrun), 32'd0);

    // Full frame consumed every cycle, then end-of-frame hands all cycles to the writer.
    start_frame_and_fill();
    rd_mode = 1;
    repeat (FRAME) tick();
    rd_mode = 0;
    tick();
    chk("t2_popped", 32'(pix_idx), 32'(FRAME));
    chk("t2_reads", 32'(rd_cnt), 32'(FRAME));
    chk("t2_underrun", 32'(underrun), 32'd0);
    chk("t2_empty", 32'(pix_valid), 32'd0);
    wr_en = 1'b1;
    repeat (20) begin
      tick();
      #1;
      chk("eof_wr_ack", 32'(wr_ack), 32'd1);
      chk("eof_no_read", 32'(ram_re), 32'd0);
    end
    wr_en = 1'b0;
    repeat (3) tick();

    // Continuous writer alongside a gapped consumer.
    start_frame_and_fill();
    n_wr = 0;
    wr_en = 1'b1;
    rd_mode = 2;
    repeat (1500) tick();
    wr_en = 1'b0;
    rd_mode = 0;
    repeat (5) tick();
    chk("t3_underrun", 32'(underrun), 32'd0);
    chk("t3_writes_done", 32'(n_wr > 300), 32'd1);
    chk("t3_wr_drained", 32'(exp_wr.size()), 32'd0);

    // Asynchronous reset mid-frame with the writer requesting.
    start_frame_and_fill();
    wr_en = 1'b1;
    rd_mode = 2;
    repeat (50) tick();
    wr_req = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t6_strobes", 32'({ram_re, ram_we, wr_ack, pix_valid, underrun}), 32'd0);
    chk("t6_ram_addr", 32'(ram_addr), 32'd0);
    chk("t6_pix_data", 32'(pix_data), 32'd0);
    wr_en = 1'b0;
    rd_mode = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    start_frame_and_fill();
    chk("t6_head", 32'(pix_data), 32'h0000);
    chk("t6_valid", 32'(pix_valid), 32'd1);
    chk("t6_reads", 32'(rd_cnt), 32'd16);
    rd_mode = 1;
    repeat (100) tick();
    rd_mode = 0;
    tick();
    chk("t6_popped", 32'(pix_idx), 32'd100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
